alu_seq_booth: RTL and testbench

- Parametrised, registered successor to the team's 16-bit combinational ALU.
- Executes one operation at a time: bitwise ops, shifts, add, subtract and signed multiply, behind a valid/ready handshake on both sides.
- Single-cycle ops complete one cycle after acceptance.
- MUL is a multi-cycle radix-2 Booth multiplier, one iteration per clock.
- Sits between the operand/opcode issue logic and the result writeback path.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/booth_mul_iter.sv | 30 +++
 rtl/alu_seq_booth.sv | 140 ++++++++++++++
 tb/tb_alu_seq_booth.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and the ADD/SUB signed-overflow rule
// used by the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_LSL  = 4'b0110;
    localparam logic [3:0] OP_LSR  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow from operand and result sign bits; sub selects a-b.
    function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                        input logic b_msb, input logic r_msb);
        if (sub) return (a_msb != b_msb) && (r_msb != a_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/booth_mul_iter.sv
// One radix-2 Booth iteration: conditional add of +/-a into the upper half,
// then arithmetic shift right by one.
module booth_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH:0]   a_ext,
    input  logic [WIDTH:0]   a_neg_ext,
    output logic [2*WIDTH:0] next_acc
);

    logic [WIDTH:0] upper;
    logic [WIDTH:0] sum;

    // The add is done one bit wider so that the bit lost to wrap-around is
    // exactly the sign bit the shift brings back in (needed for a = -2^(W-1)).
    assign upper = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};

    always_comb begin
        sum = upper;
        case (acc[1:0])
            2'b01:   sum = upper + a_ext;
            2'b10:   sum = upper + a_neg_ext;
            default: sum = upper;
        endcase
    end

    assign next_acc = {sum, acc[WIDTH:1]};

endmodule

// File: rtl/alu_seq_booth.sv
// Registered single-issue ALU: logic ops, shifts, add/sub in one cycle,
// signed Booth multiply over WIDTH cycles, valid/ready on both sides.
module alu_seq_booth
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               overflow,
    output logic               illegal,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // out_valid holds result and flags stable until out_ready is seen.
    state_t state, state_nx;

    logic [2*WIDTH:0] acc, next_acc;
    logic [WIDTH:0]   a_ext, a_neg_ext, a_sx;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_v, alu_ill;
    logic [WIDTH:0]   add_w, sub_w;
    logic             shift_big;

    assign a_sx      = {a[WIDTH-1], a};
    assign add_w     = {1'b0, a} + {1'b0, b};
    assign sub_w     = {1'b0, a} - {1'b0, b};
    assign shift_big = (b >= WIDTH'(WIDTH));

    always_comb begin
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_AND:  alu_r = a & b;
            OP_OR:   alu_r = a | b;
            OP_NAND: alu_r = ~(a & b);
            OP_NOR:  alu_r = ~(a | b);
            OP_XOR:  alu_r = a ^ b;
            OP_XNOR: alu_r = ~(a ^ b);
            OP_LSL:  alu_r = shift_big ? '0 : (a << b);
            OP_LSR:  alu_r = shift_big ? '0 : (a >> b);
            OP_ADD: begin
                alu_r = add_w[WIDTH-1:0];
                alu_c = add_w[WIDTH];
                alu_v = signed_ovf(1'b0, a[WIDTH-1], b[WIDTH-1], add_w[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = sub_w[WIDTH-1:0];
                alu_c = sub_w[WIDTH];
                alu_v = signed_ovf(1'b1, a[WIDTH-1], b[WIDTH-1], sub_w[WIDTH-1]);
            end
            OP_MUL:  alu_r = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    booth_mul_iter #(.WIDTH(WIDTH)) u_step (
        .acc       (acc),
        .a_ext     (a_ext),
        .a_neg_ext (a_neg_ext),
        .next_acc  (next_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = (opcode == OP_MUL) ? MUL : DONE;
            MUL:  if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            a_ext     <= '0;
            a_neg_ext <= '0;
            cnt       <= '0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (opcode == OP_MUL) begin
                        acc       <= {{WIDTH{1'b0}}, b, 1'b0};
                        a_ext     <= a_sx;
                        a_neg_ext <= -a_sx;
                        cnt       <= CNT_W'(WIDTH);
                    end else begin
                        result   <= {{WIDTH{alu_r[WIDTH-1]}}, alu_r};
                        carry    <= alu_c;
                        overflow <= alu_v;
                        illegal  <= alu_ill;
                    end
                end
                MUL: begin
                    acc <= next_acc;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result   <= next_acc[2*WIDTH:1];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_booth.sv
// Bench for alu_seq_booth: directed cases plus random ops checked against an
// arithmetic reference model through an expected-result queue.
module tb_alu_seq_booth;

    localparam int W = 16;
    localparam logic [3:0] T_AND = 4'b0000, T_OR  = 4'b0001, T_LSL = 4'b0110;
    localparam logic [3:0] T_LSR = 4'b0111, T_ADD = 4'b1000, T_SUB = 4'b1001;
    localparam logic [3:0] T_MUL = 4'b1010;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     opcode = '0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic           carry, overflow, illegal;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];
    logic [15:0] corners[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    alu_seq_booth #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry(carry),
        .overflow(overflow), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] r);
        return {{16{r[15]}}, r};
    endfunction

    // Reference: {illegal, overflow, carry, result} from plain arithmetic.
    function automatic logic [34:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] res;
        logic        c, v, il;
        longint      sx, sy, s;
        logic [15:0] t;
        res = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            4'd0: res = sext(x & y);
            4'd1: res = sext(x | y);
            4'd2: res = sext(~(x & y));
            4'd3: res = sext(~(x | y));
            4'd4: res = sext(x ^ y);
            4'd5: res = sext(~(x ^ y));
            4'd6: begin t = x << y; res = (y >= 16) ? 32'd0 : sext(t); end
            4'd7: begin t = x >> y; res = (y >= 16) ? 32'd0 : sext(t); end
            4'd8: begin
                s = longint'(x) + longint'(y);
                c = (s > 65535);
                v = ((sx + sy) > 32767) || ((sx + sy) < -32768);
                res = sext(s[15:0]);
            end
            4'd9: begin
                t = x - y;
                c = (x < y);
                v = ((sx - sy) > 32767) || ((sx - sy) < -32768);
                res = sext(t);
            end
            4'd10: begin s = sx * sy; res = s[31:0]; end
            default: il = 1'b1;
        endcase
        return {il, v, c, res};
    endfunction

    // Every cycle a result is presented it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %0h with nothing expected", result);
            end else begin
                check("out_fields", {illegal, overflow, carry, result}, exp_q[0]);
                check("in_ready_while_done", in_ready, 1'b0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int n = 0;
        opcode = op; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        exp_q.push_back(model(op, x, y));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [3:0] op);
        int lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, (op == T_MUL) ? 17 : 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_lit(input string name, input logic [3:0] op, input logic [15:0] x,
                           input logic [15:0] y, input logic [34:0] exp);
        send(op, x, y);
        wait_result(op);
        check(name, {illegal, overflow, carry, result}, exp);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] x, y;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_flags", {illegal, overflow, carry, result}, 35'd0);

        check("model_add_ovf", model(T_ADD, 16'h7FFF, 16'h0001), {1'b0, 1'b1, 1'b0, 32'hFFFF8000});
        check("model_mul_min", model(T_MUL, 16'h8000, 16'h8000), {3'b000, 32'h40000000});
        check("model_lsr", model(T_LSR, 16'h8000, 16'd3), {3'b000, 32'h00001000});

        run_lit("add_overflow", T_ADD, 16'h7FFF, 16'h0001, {1'b0, 1'b1, 1'b0, 32'hFFFF8000});
        run_lit("sub_borrow",   T_SUB, 16'h0003, 16'h0005, {1'b0, 1'b0, 1'b1, 32'hFFFFFFFE});
        run_lit("add_carry",    T_ADD, 16'hFFFF, 16'h0001, {1'b0, 1'b0, 1'b1, 32'h00000000});
        run_lit("mul_neg",      T_MUL, 16'hFFFD, 16'h0007, {3'b000, 32'hFFFFFFEB});
        run_lit("mul_min",      T_MUL, 16'h8000, 16'h8000, {3'b000, 32'h40000000});
        run_lit("lsl_15",       T_LSL, 16'h0001, 16'd15,   {3'b000, 32'hFFFF8000});
        run_lit("lsl_16",       T_LSL, 16'h0001, 16'd16,   {3'b000, 32'h00000000});
        run_lit("lsr_3",        T_LSR, 16'h8000, 16'd3,    {3'b000, 32'h00001000});

        // Backpressure: result held, new request ignored until released.
        out_ready = 1'b0;
        send(T_AND, 16'h00F0, 16'h0FF0);
        wait_result(T_AND);
        opcode = T_OR; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_result_held", result, 32'h000000F0);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_out_valid", out_valid, 1'b0);
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("bp_no_second_accept", out_valid, 1'b0);

        // Reset on the fifth cycle of a multiply discards it.
        send(T_MUL, 16'h1234, 16'h5678);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_result", result, 32'd0);
        repeat (20) begin @(posedge clk); #1; end
        check("rst_mid_no_late_result", out_valid, 1'b0);

        run_lit("illegal_op", 4'hF, 16'hABCD, 16'h1234, {1'b1, 2'b00, 32'h00000000});

        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 19);
            op = (r >= 16) ? T_MUL : 4'(r);
            x  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            if (op == T_LSL || op == T_LSR) y = 16'($urandom_range(0, 20));
            else if ($urandom_range(0, 3) == 0) y = corners[$urandom_range(0, 4)];
            else y = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            send(op, x, y);
            wait_result(op);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drain();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) begin @(posedge clk); #1; end
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
